// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shifter/rotator walking barrel stages 8,4,2,1 with a valid/ready handshake.
// Define SHIFT_SEQ_SKIP_EN to visit only the stages whose shift-count bit is set (early-out).
module shift_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned OP_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [OP_W-1:0] OP_SLL = 2'b00;
  localparam logic [OP_W-1:0] OP_ROL = 2'b01;
  localparam logic [OP_W-1:0] OP_SRA = 2'b10;

  // One barrel stage; the SRA fill reads the current MSB, which never changes under SRA.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                   input logic [CNT_W-1:0] amt,
                                                   input logic [OP_W-1:0]  op);
    logic [WIDTH-1:0] r;
    unique case (op)
      OP_SLL:  r = d << amt;
      OP_ROL:  r = (d << amt) | (d >> (5'(WIDTH) - 5'(amt)));
      OP_SRA:  r = $unsigned($signed(d) >>> amt);
      default: r = d >> amt;
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             start_ready_q, start_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] amt;
`ifndef SHIFT_SEQ_SKIP_EN
  logic [1:0]       stage_q, stage_d;
`endif

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    amt     = '0;
`ifndef SHIFT_SEQ_SKIP_EN
    stage_d = stage_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          data_d = in_data;
          cnt_d  = in_cnt;
          op_d   = in_op;
`ifdef SHIFT_SEQ_SKIP_EN
          state_d = (in_cnt == '0) ? DONE : SHIFT;
`else
          stage_d = '0;
          state_d = SHIFT;
`endif
        end
      end
      SHIFT: begin
`ifdef SHIFT_SEQ_SKIP_EN
        // cnt_q holds the stages still pending; take the heaviest one and retire it.
        if (cnt_q[3])      amt = 4'd8;
        else if (cnt_q[2]) amt = 4'd4;
        else if (cnt_q[1]) amt = 4'd2;
        else               amt = 4'd1;
        data_d = shift_stage(data_q, amt, op_q);
        cnt_d  = cnt_q & ~amt;
        if (cnt_d == '0) state_d = DONE;
`else
        amt     = cnt_q[2'd3 - stage_q] ? (4'd8 >> stage_q) : 4'd0;
        data_d  = shift_stage(data_q, amt, op_q);
        stage_d = stage_q + 2'd1;
        if (stage_q == 2'd3) state_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_ready_d = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    out_valid_d   = (state_d == DONE);
    out_data_d    = (state_d == DONE) ? data_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      data_q        <= '0;
      cnt_q         <= '0;
      op_q          <= '0;
      start_ready_q <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      busy_q        <= 1'b0;
`ifndef SHIFT_SEQ_SKIP_EN
      stage_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      start_ready_q <= start_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      busy_q        <= busy_d;
`ifndef SHIFT_SEQ_SKIP_EN
      stage_q       <= stage_d;
`endif
    end
  end

  assign start_ready = start_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: reset, op/count vectors, latency, backpressure, mid-shift reset.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  shift_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .in_data(in_data), .in_cnt(in_cnt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [3:0] c);
`ifdef SHIFT_SEQ_SKIP_EN
    return int'(c[0]) + int'(c[1]) + int'(c[2]) + int'(c[3]);
`else
    return 4;
`endif
  endfunction

  // Wait for IDLE, present a command, leave right after the acceptance edge and scramble inputs.
  task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op);
    int g = 0;
    @(negedge clk);
    while (start_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (g >= 50) begin
      n_err++;
      $display("FAIL send_wait: start_ready=%b required 1", start_ready);
    end
    in_data = d; in_cnt = c; in_op = op; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    in_data = ~d; in_cnt = ~c; in_op = ~op;
  endtask

  // Count edges after acceptance until out_valid, then check latency and result.
  task automatic wait_result(input string name, input logic [15:0] exp, input int elat);
    int lat = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_cmp++;
    if (lat !== elat) begin
      n_err++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, elat);
    end
    n_cmp++;
    if (out_data !== exp) begin
      n_err++;
      $display("FAIL %s_data: got %h required %h", name, out_data, exp);
    end
    n_cmp++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done_flags: busy=%b start_ready=%b required 1/0", name, busy, start_ready);
    end
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || busy !== 1'b0 || start_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_return: valid=%b data=%h busy=%b ready=%b required 0/0000/0/1",
               name, out_valid, out_data, busy, start_ready);
    end
  endtask

  task automatic run_cmd(input string name, input logic [15:0] d, input logic [3:0] c,
                         input logic [1:0] op, input logic [15:0] exp);
    send(d, c, op);
    wait_result(name, exp, exp_lat(c));
    consume(name);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_cnt = '0; in_op = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    n_cmp++;
    if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h required 0000", out_data); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++;
    if (start_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", start_ready); end
  endtask

  task automatic test_ops;
    run_cmd("sll_ff_4",    16'h00FF, 4'd4,  2'b00, 16'h0FF0);
    run_cmd("sra_8000_15", 16'h8000, 4'd15, 2'b10, 16'hFFFF);
    run_cmd("srl_f000_12", 16'hF000, 4'd12, 2'b11, 16'h000F);
    run_cmd("rol_8001_8",  16'h8001, 4'd8,  2'b01, 16'h0180);
    run_cmd("rol_8001_1",  16'h8001, 4'd1,  2'b01, 16'h0003);
    run_cmd("sll_1234_0",  16'h1234, 4'd0,  2'b00, 16'h1234);
    run_cmd("sra_7f00_4",  16'h7F00, 4'd4,  2'b10, 16'h07F0);
    run_cmd("sra_8f00_3",  16'h8F00, 4'd3,  2'b10, 16'hF1E0);
    run_cmd("srl_8f00_3",  16'h8F00, 4'd3,  2'b11, 16'h11E0);
    run_cmd("rol_1234_4",  16'h1234, 4'd4,  2'b01, 16'h2341);
    run_cmd("rol_1234_12", 16'h1234, 4'd12, 2'b01, 16'h4123);
    run_cmd("rol_abcd_15", 16'hABCD, 4'd15, 2'b01, 16'hD5E6);
    run_cmd("sll_ffff_15", 16'hFFFF, 4'd15, 2'b00, 16'h8000);
    run_cmd("srl_ffff_15", 16'hFFFF, 4'd15, 2'b11, 16'h0001);
    run_cmd("sll_0003_5",  16'h0003, 4'd5,  2'b00, 16'h0060);
  endtask

  task automatic test_idle_out_ready;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_out_ready: valid=%b busy=%b ready=%b required 0/0/1", out_valid, busy, start_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    send(16'h00FF, 4'd4, 2'b00);
    wait_result("bp_first", 16'h0FF0, exp_lat(4'd4));
    in_data = 16'h0F0F; in_cnt = 4'd1; in_op = 2'b00; start_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_data !== 16'h0FF0 || out_valid !== 1'b1 || start_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: data=%h valid=%b ready=%b required 0ff0/1/0",
                 i, out_data, out_valid, start_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
      n_err++;
      $display("FAIL bp_idle: ready=%b valid=%b data=%h required 1/0/0000", start_ready, out_valid, out_data);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    in_data = 16'hFFFF; in_cnt = 4'd9; in_op = 2'b11;
    wait_result("bp_next", 16'h1E1E, exp_lat(4'd1));
    consume("bp_next");
  endtask

  task automatic test_reset_mid_shift;
    int stray = 0;
    send(16'h1234, 4'd15, 2'b01);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: valid=%b data=%h busy=%b required 0/0000/0", out_valid, out_data, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (start_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b required 1", start_ready); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin n_err++; $display("FAIL rst_mid_stale: got %0d active cycles required 0", stray); end
    run_cmd("post_rst", 16'h0001, 4'd7, 2'b00, 16'h0080);
  endtask

  initial begin
    test_reset();
    test_ops();
    test_idle_out_ready();
    test_backpressure();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data width in bits; only 16 is supported.
REQ-002 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start_valid  input  1  requester presents a shift command.
REQ-005 The block SHALL have port start_ready  output  1  block can accept a command.
REQ-006 The block SHALL have port in_data  input  16  operand.
REQ-007 The block SHALL have port in_cnt  input  4  shift amount, 0-15.
REQ-008 The block SHALL have port in_op  input  2  operation: 00 shift left logical, 01 rotate left, 10 shift right arithmetic, 11 shift right logical.
REQ-009 The block SHALL have port out_valid  output  1  result available.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 The block SHALL have port out_data  output  16  result.
REQ-012 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-014 start_ready SHALL be high only in IDLE; a command is accepted on a rising edge where start_valid and start_ready are both high.
REQ-015 On acceptance, in_data, in_cnt and in_op SHALL be registered; input changes after acceptance SHALL be ignored.
REQ-016 SHIFT SHALL step through stages of weight 8, 4, 2 and 1, one stage per cycle, most significant first; a stage shifts by its weight only when the matching in_cnt bit is set, otherwise it passes data unchanged.
REQ-017 Vacated bits SHALL be filled with 0 for ops 00 and 11, with the registered bit 15 for op 10, and with the wrapped-out bits for op 01.
REQ-018 Without the configuration macro, the acceptance edge SHALL enter SHIFT, the next 4 edges SHALL apply stages 8, 4, 2 and 1, and the 4th of these edges SHALL enter DONE: 4 cycles from acceptance to out_valid, independent of in_cnt.
REQ-019 In DONE, out_valid SHALL be high and out_data SHALL hold the final result stable until the edge where out_ready is high; that edge SHALL return the block to IDLE.
REQ-020 out_data SHALL be 0x0000 whenever out_valid is low.
REQ-021 A start_valid that is high while the block is busy SHALL be neither accepted nor lost; it waits for IDLE.
REQ-022 out_ready while out_valid is low SHALL have no effect.
REQ-023 The result SHALL be bit-exact with a single-step 16-bit shift of the same op and count for all 16 counts and all 4 ops.

Reset
REQ-024 Asserting rst_n low SHALL immediately force IDLE, out_valid 0, out_data 0x0000, busy 0 and clear all internal registers, in any state including mid-SHIFT.
REQ-025 start_ready SHALL be 1 while in IDLE following reset release; a command interrupted by reset SHALL be discarded.

Configuration
REQ-026 Macro SHIFT_SEQ_SKIP_EN SHALL select early-out sequencing.
REQ-027 With SHIFT_SEQ_SKIP_EN defined, SHIFT SHALL visit only stages whose in_cnt bit is set, so latency from acceptance to out_valid equals popcount(in_cnt) cycles; in_cnt 0 SHALL go straight from acceptance to DONE, with out_valid high in the cycle after the acceptance edge.
REQ-028 Without SHIFT_SEQ_SKIP_EN, the fixed 4-cycle latency of REQ-018 SHALL apply.

Verification
REQ-029 Op 00, in_data 0x00FF, in_cnt 4 -> out_data 0x0FF0, out_valid rises 4 cycles after acceptance (macro off).
REQ-030 Op 10, in_data 0x8000, in_cnt 15 -> 0xFFFF; op 11, in_data 0xF000, in_cnt 12 -> 0x000F.
REQ-031 Op 01, in_data 0x8001, in_cnt 8 -> 0x0180; op 01, in_data 0x8001, in_cnt 1 -> 0x0003.
REQ-032 Hold out_ready low for 3 cycles in DONE while start_valid is high -> out_data stable, start_ready 0, no acceptance; out_ready high -> IDLE, then the new command is accepted.
REQ-033 Drop rst_n during the 2nd SHIFT cycle -> out_valid 0, out_data 0x0000, busy 0 at once; after release start_ready 1 and no stale result appears.
REQ-034 With SHIFT_SEQ_SKIP_EN: in_cnt 0 -> in_data returned with out_valid in the cycle after acceptance; in_cnt 5 -> out_valid after 2 cycles; in_cnt 15 -> out_valid after 4 cycles.
